// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchroniser, 8N1 deserialiser and byte FIFO with ready/valid read port.
// Define UART_RX_PARITY_EN to receive 8E1 frames and report parity errors.
module uart_rx #(
  parameter int DIV        = 868,
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rdata,
  output logic       rvalid,
  input  logic       rready,
  output logic       overrun,
  input  logic       overrun_clr,
  output logic       frame_err,
  output logic       parity_err
);

  localparam int CW = $clog2(DIV);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] HALF_M1 = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(DIV - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    WAIT_IDLE
  } state_e;

  state_e          state_q;
  logic            rx_s1_q, rxs_q;
  logic [CW-1:0]   cnt_q;
  logic [2:0]      idx_q;
  logic [7:0]      sh_q;
  logic            frame_err_q;
  logic            stop_smp;
  logic            push_w;

  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_s1_q <= 1'b1;
      rxs_q   <= 1'b1;
    end else begin
      rx_s1_q <= rx;
      rxs_q   <= rx_s1_q;
    end
  end

  assign stop_smp = (state_q == STOP) && (cnt_q == '0);

`ifdef UART_RX_PARITY_EN
  logic par_q;
  logic parity_err_q;
  assign push_w     = stop_smp && rxs_q && !par_q;
  assign parity_err = parity_err_q;
`else
  assign push_w     = stop_smp && rxs_q;
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      sh_q         <= '0;
      frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q        <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (!rxs_q) begin
            state_q <= START;
            cnt_q   <= HALF_M1;
          end
        end
        START: begin
          if (cnt_q == '0) begin
            if (!rxs_q) begin
              state_q <= DATA;
              cnt_q   <= FULL_M1;
              idx_q   <= '0;
`ifdef UART_RX_PARITY_EN
              par_q   <= 1'b0;
`endif
            end else begin
              state_q <= IDLE;
            end
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        DATA: begin
          if (cnt_q == '0) begin
            sh_q  <= {rxs_q, sh_q[7:1]};
            cnt_q <= FULL_M1;
            idx_q <= idx_q + 3'd1;
            if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_q <= PARITY;
`else
              state_q <= STOP;
`endif
            end
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (cnt_q == '0) begin
            par_q   <= ^{sh_q, rxs_q};
            cnt_q   <= FULL_M1;
            state_q <= STOP;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
`endif
        STOP: begin
          if (cnt_q == '0) begin
            if (rxs_q) begin
`ifdef UART_RX_PARITY_EN
              if (par_q) parity_err_q <= 1'b1;
`endif
              state_q <= IDLE;
            end else begin
              frame_err_q <= 1'b1;
              state_q     <= WAIT_IDLE;
            end
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        WAIT_IDLE: begin
          if (rxs_q) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign frame_err = frame_err_q;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [7:0]  mem_q [FIFO_DEPTH];
  logic [AW:0] wptr_q, rptr_q;
  logic        empty_w, full_w, pop_w, wr_w, ovf_w;
  logic        overrun_q;

  assign empty_w = (wptr_q == rptr_q);
  assign full_w  = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
  assign pop_w   = !empty_w && rready;
  assign wr_w    = push_w && (!full_w || pop_w);
  assign ovf_w   = push_w && full_w && !pop_w;

  always_ff @(posedge clk) begin
    if (wr_w) mem_q[wptr_q[AW-1:0]] <= sh_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (wr_w)  wptr_q <= wptr_q + (AW+1)'(1);
      if (pop_w) rptr_q <= rptr_q + (AW+1)'(1);
      if (ovf_w)            overrun_q <= 1'b1;
      else if (overrun_clr) overrun_q <= 1'b0;
    end
  end

  assign rvalid  = !empty_w;
  assign rdata   = empty_w ? '0 : mem_q[rptr_q[AW-1:0]];
  assign overrun = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx (DIV=16, FIFO_DEPTH=4); adapts frame length when UART_RX_PARITY_EN is defined.
module tb_uart_rx;

  localparam int BIT = 16;
`ifdef UART_RX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  // Ticks from driving the start bit until just after the stop-sample edge.
  localparam int STOP_T = 2 + BIT / 2 + (NB - 1) * BIT + 1;

  logic       clk = 1'b0;
  logic       rst, rx, rready, overrun_clr;
  logic [7:0] rdata;
  logic       rvalid, overrun, frame_err, parity_err;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int fe_cnt   = 0;
  int pe_cnt   = 0;

  logic rv_pre, rv_at, fe_at, fe_after, pe_at, pe_after;

  uart_rx #(.DIV(BIT), .FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .rdata      (rdata),
    .rvalid     (rvalid),
    .rready     (rready),
    .overrun    (overrun),
    .overrun_clr(overrun_clr),
    .frame_err  (frame_err),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (frame_err)  fe_cnt <= fe_cnt + 1;
    if (parity_err) pe_cnt <= pe_cnt + 1;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pop_check(input string tag, input logic [7:0] exp);
    check(tag, rdata, exp);
    rready = 1'b1;
    tick;
    rready = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic parb, input logic stopb,
                            input int extra_low, input logic pop_at_stop, input logic clr_at_stop);
    logic [10:0] bits;
    bits      = '1;
    bits[0]   = 1'b0;
    bits[8:1] = d;
`ifdef UART_RX_PARITY_EN
    bits[9]   = parb;
    bits[10]  = stopb;
`else
    bits[9]   = stopb;
`endif
    for (int i = 0; i < NB * BIT; i++) begin
      rx = bits[i / BIT];
      if (i == STOP_T - 1) begin
        rready      = pop_at_stop;
        overrun_clr = clr_at_stop;
      end
      tick;
      if (i == STOP_T - 1) begin
        rready      = 1'b0;
        overrun_clr = 1'b0;
      end
      if (i + 1 == STOP_T - 1) rv_pre = rvalid;
      if (i + 1 == STOP_T) begin
        rv_at = rvalid;
        fe_at = frame_err;
        pe_at = parity_err;
      end
      if (i + 1 == STOP_T + 1) begin
        fe_after = frame_err;
        pe_after = parity_err;
      end
    end
    if (extra_low > 0) begin
      rx = 1'b0;
      repeat (extra_low) tick;
    end
    rx = 1'b1;
  endtask

  initial begin
    rst = 1'b0; rx = 1'b1; rready = 1'b0; overrun_clr = 1'b0;
    repeat (3) tick;
    check("rst_rvalid", rvalid, 1'b0);
    check("rst_rdata", rdata, 8'h00);
    check("rst_overrun", overrun, 1'b0);
    check("rst_frame_err", frame_err, 1'b0);
    check("rst_parity_err", parity_err, 1'b0);
    rst = 1'b1;
    repeat (5) tick;

    // Single byte with exact latency to rvalid
    send_frame(8'hA5, ^8'hA5, 1'b1, 0, 1'b0, 1'b0);
    check("a5_rvalid_before", rv_pre, 1'b0);
    check("a5_rvalid_at", rv_at, 1'b1);
    check("a5_no_frame_err", fe_at, 1'b0);
    pop_check("a5_data", 8'hA5);
    check("a5_empty_after_pop", rvalid, 1'b0);
    check("a5_rdata_zero", rdata, 8'h00);

    // Short low glitch is ignored
    rx = 1'b0;
    repeat (4) tick;
    rx = 1'b1;
    repeat (40) tick;
    check("glitch_rvalid", rvalid, 1'b0);
    check("glitch_fe_cnt", fe_cnt, 0);

    // Framing error followed by a break, then a good frame
    send_frame(8'h3C, ^8'h3C, 1'b0, 40, 1'b0, 1'b0);
    check("fe_pulse", fe_at, 1'b1);
    check("fe_one_cycle", fe_after, 1'b0);
    repeat (20) tick;
    check("fe_once", fe_cnt, 1);
    check("fe_no_push", rvalid, 1'b0);
    send_frame(8'h11, ^8'h11, 1'b1, 0, 1'b0, 1'b0);
    check("after_fe_rvalid", rv_at, 1'b1);
    pop_check("after_fe_data", 8'h11);

    // Reset mid-frame abandons the frame
    rx = 1'b0;
    repeat (80) tick;
    rst = 1'b0;
    rx  = 1'b1;
    tick;
    rst = 1'b1;
    repeat (200) tick;
    check("midrst_no_push", rvalid, 1'b0);
    check("midrst_no_fe", fe_cnt, 1);

    // Fill FIFO then overflow
    for (int b = 1; b <= 4; b++) send_frame(8'(b), ^8'(b), 1'b1, 0, 1'b0, 1'b0);
    check("full_no_overrun", overrun, 1'b0);
    check("full_head", rdata, 8'h01);
    send_frame(8'h05, ^8'h05, 1'b1, 0, 1'b0, 1'b0);
    check("overrun_set", overrun, 1'b1);
    check("overrun_head", rdata, 8'h01);
    overrun_clr = 1'b1;
    tick;
    overrun_clr = 1'b0;
    check("overrun_cleared", overrun, 1'b0);
    for (int b = 1; b <= 4; b++) pop_check("fifo_order", 8'(b));
    check("fifo_empty", rvalid, 1'b0);

    // Simultaneous push and pop while full
    for (int b = 1; b <= 4; b++) send_frame(8'(b), ^8'(b), 1'b1, 0, 1'b0, 1'b0);
    send_frame(8'h06, ^8'h06, 1'b1, 0, 1'b1, 1'b0);
    check("pushpop_no_overrun", overrun, 1'b0);
    check("pushpop_head", rdata, 8'h02);
    // New overrun beats a same-cycle clear
    send_frame(8'h07, ^8'h07, 1'b1, 0, 1'b0, 1'b1);
    check("overrun_wins_clr", overrun, 1'b1);
    overrun_clr = 1'b1;
    tick;
    overrun_clr = 1'b0;
    pop_check("pp_order0", 8'h02);
    pop_check("pp_order1", 8'h03);
    pop_check("pp_order2", 8'h04);
    pop_check("pp_tail", 8'h06);
    check("pp_empty", rvalid, 1'b0);
    check("pp_rdata_zero", rdata, 8'h00);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b0, 1'b1, 0, 1'b0, 1'b0);
    check("pe_pulse", pe_at, 1'b1);
    check("pe_one_cycle", pe_after, 1'b0);
    check("pe_no_push", rv_at, 1'b0);
    send_frame(8'h07, 1'b1, 1'b1, 0, 1'b0, 1'b0);
    check("pe_ok_rvalid", rv_at, 1'b1);
    check("pe_ok_no_pulse", pe_at, 1'b0);
    pop_check("pe_ok_data", 8'h07);
`endif

    repeat (5) tick;
    check("total_fe", fe_cnt, 1);
`ifdef UART_RX_PARITY_EN
    check("total_pe", pe_cnt, 1);
`else
    check("total_pe", pe_cnt, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
